el_scan_out: RTL and testbench
==============================

Name: el_scan_out

Overview:
- Downstream neighbour of the DVI input/dither stage.
- That stage writes 2-bit-per-pixel dithered frames into a dual-port frame RAM, 4 pixels per byte:
  - bits[3:0]: low-threshold plane.
  - bits[7:4]: high-threshold plane.
  - Byte address = line*80 + pixel/4.
- This block reads that RAM through the read port and drives the EL panel's 4-bit data bus with pixel clock, line sync and frame sync.
- Grey levels come from frame-rate control between the two planes.

Parameters:
- H_BYTES, 80: bytes (nibble transfers) per panel line; 320 px.
- V_LINES, 240: panel lines per frame.
- CLK_DIV, 4: clk cycles per panel pixel-clock period; must be even and >= 4.
- HS_LEN, 4: pixel periods elHs is high at the start of each line.
- V_BLANK, 16: idle pixel periods after the last line, before the next frame.

Ports:
- clk, in, 1: system clock; RAM read port is synchronous to it.
- rst, in, 1: synchronous active-high reset.
- enable, in, 1: run scan-out; sampled only at frame boundaries.
- rdAddr, out, 15: frame RAM read address.
- rdEn, out, 1: read strobe; RAM returns rdData exactly 1 clk later.
- rdData, in, 8: RAM read data.
- elData, out, 4: panel pixel nibble, leftmost pixel in bit 3.
- elVclk, out, 1: panel pixel clock; panel samples elData on its falling edge.
- elHs, out, 1: line sync.
- elVs, out, 1: frame sync.
- frameParity, out, 1: toggles each completed frame.
- frameStart, out, 1: 1-clk pulse when line 0 begins.

Behaviour:
- Reset: on any clk with rst=1, all outputs go to 0, the FSM goes to IDLE, and all counters go to 0. Applies mid-frame too; the next frame starts from line 0.
- Tick generator:
  - Divider counts 0..CLK_DIV-1.
  - tick = 1 clk pulse at count 0.
  - elVclk is high for counts CLK_DIV/2..CLK_DIV-1 while in DATA, otherwise 0.
  - Divider runs only outside IDLE.
- FSM states: IDLE, HSYNC, DATA, VBLANK.
- IDLE:
  - All outputs 0.
  - enable=1 → HSYNC with line=0, addr=0, divider=0.
  - frameStart pulses in the same clk as this transition.
- HSYNC:
  - elHs=1 for HS_LEN ticks.
  - elVs=1 additionally when line==0.
  - Then → DATA with byte=0.
- DATA: one byte per tick.
  - At tick: rdEn=1, rdAddr = line*H_BYTES + byte. The running address counter increments by 1; no multiply is needed.
  - 1 clk after tick: elData = plane nibble of rdData.
  - elData is held for the full pixel period, so it is stable before elVclk rises.
  - After byte H_BYTES-1's period, line increments:
    - line < V_LINES → HSYNC.
    - line == V_LINES → VBLANK.
- VBLANK:
  - V_BLANK ticks, outputs low.
  - frameParity toggles on entry.
  - Then: enable=1 → HSYNC line 0 (frameStart pulse); enable=0 → IDLE.
- enable deasserted mid-frame: the frame completes normally, then the block goes idle. enable reasserted during VBLANK: no effect until VBLANK ends.
- Address wrap:
  - rdAddr range is 0..H_BYTES*V_LINES-1 (19199).
  - The counter reloads to 0 at each frame start and never wraps mid-frame.
- Plane select:
  - frameParity=0 → rdData[3:0].
  - frameParity=1 → rdData[7:4].
  - Net brightness is 0, 1/2 or 1.
- rdEn is high only on DATA ticks. No reads in IDLE, HSYNC or VBLANK.
- Frame length in ticks: V_LINES*(HS_LEN+H_BYTES) + V_BLANK. Defaults: 240*84+16 = 20176 ticks = 80704 clk.

Optional Feature:
- Macro: EL_FRC_GRAY_EN.
- Defined: plane alternates with frameParity as above, giving 3 grey levels.
- Undefined:
  - elData always = rdData[7:4], the high plane (1-bit mono).
  - frameParity still toggles per frame.
  - The plane mux is removed.

Test Plan:
- Reset/idle: rst=1 for 3 clk, enable=0 → all outputs 0 for 1000 clk; rdEn never asserted.
- First line, defaults:
  - Stimulus: enable=1, RAM model with byte[a] = a[7:0].
  - Required: frameStart pulse; elHs and elVs high for 16 clk; then rdAddr 0..79 at 4-clk spacing.
  - Required: elData on frame 0 = low nibble of the address, valid at each elVclk fall.
- Line stride: line 1 → first rdAddr=80, elVs=0 during its HSYNC. Line 239 → last rdAddr=19199, then VBLANK of 64 clk with no rdEn.
- FRC: RAM filled with 0xF0 → elData=0x0 on frame 0 and 0xF on frame 1; frameParity toggles each 80704 clk. With EL_FRC_GRAY_EN undefined → elData=0xF both frames.
- Enable drop: enable→0 at line 100 → frame completes to rdAddr 19199, then IDLE; no further frameStart.
- Reset mid-frame: rst pulse at line 50 → outputs 0 next clk. With enable still 1, the next frame starts at rdAddr 0 with a frameStart pulse.

Source files
------------

// File: rtl/el_scan_out.sv
// el_scan_out: reads the dithered frame RAM and drives the EL panel nibble bus, pixel clock and syncs.
// Build option EL_FRC_GRAY_EN: alternate bit planes per frame for 3 grey levels; default is mono.
module el_scan_out #(
  parameter int unsigned H_BYTES = 80,
  parameter int unsigned V_LINES = 240,
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned HS_LEN  = 4,
  parameter int unsigned V_BLANK = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic [14:0] rdAddr,
  output logic        rdEn,
  input  logic [7:0]  rdData,
  output logic [3:0]  elData,
  output logic        elVclk,
  output logic        elHs,
  output logic        elVs,
  output logic        frameParity,
  output logic        frameStart
);

  localparam int unsigned DivW   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned CntMx1 = (H_BYTES > HS_LEN) ? H_BYTES : HS_LEN;
  localparam int unsigned CntMax = (CntMx1 > V_BLANK) ? CntMx1 : V_BLANK;
  localparam int unsigned CntW   = (CntMax > 2) ? $clog2(CntMax) : 1;
  localparam int unsigned LineW  = (V_LINES > 2) ? $clog2(V_LINES) : 1;

  localparam logic [DivW-1:0]  DivLast     = DivW'(CLK_DIV - 1);
  localparam logic [DivW-1:0]  DivHalf     = DivW'(CLK_DIV / 2);
  localparam logic [CntW-1:0]  CntHsLast   = CntW'(HS_LEN - 1);
  localparam logic [CntW-1:0]  CntDataLast = CntW'(H_BYTES - 1);
  localparam logic [CntW-1:0]  CntVbLast   = CntW'(V_BLANK - 1);
  localparam logic [LineW-1:0] LineLast    = LineW'(V_LINES - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] HSYNC  = 2'd1;
  localparam logic [1:0] DATA   = 2'd2;
  localparam logic [1:0] VBLANK = 2'd3;

  logic [1:0]       stateQ, stateD;
  logic [DivW-1:0]  divQ, divD;
  logic [CntW-1:0]  cntQ, cntD;
  logic [LineW-1:0] lineQ, lineD;
  logic [14:0]      addrQ, addrD;
  logic             parityQ, parityD;
  logic             rdValidQ;
  logic [3:0]       holdQ;
  logic [3:0]       planeNib;
  logic             tick, periodEnd, startPulse;

  assign tick      = (stateQ != IDLE) && (divQ == '0);
  assign periodEnd = (stateQ != IDLE) && (divQ == DivLast);

  // cntQ counts sync ticks in HSYNC, bytes in DATA and blank ticks in VBLANK.
  always_comb begin
    stateD     = stateQ;
    divD       = divQ;
    cntD       = cntQ;
    lineD      = lineQ;
    addrD      = addrQ;
    parityD    = parityQ;
    startPulse = 1'b0;
    if (stateQ != IDLE) begin
      divD = periodEnd ? '0 : divQ + 1'b1;
    end
    unique case (stateQ)
      IDLE: begin
        if (enable) begin
          startPulse = 1'b1;
          stateD     = HSYNC;
          divD       = '0;
          cntD       = '0;
          lineD      = '0;
          addrD      = '0;
        end
      end
      HSYNC: begin
        if (periodEnd) begin
          if (cntQ == CntHsLast) begin
            stateD = DATA;
            cntD   = '0;
          end else begin
            cntD = cntQ + 1'b1;
          end
        end
      end
      DATA: begin
        if (periodEnd) begin
          addrD = addrQ + 1'b1;
          if (cntQ == CntDataLast) begin
            cntD = '0;
            if (lineQ == LineLast) begin
              stateD  = VBLANK;
              parityD = ~parityQ;
            end else begin
              stateD = HSYNC;
              lineD  = lineQ + 1'b1;
            end
          end else begin
            cntD = cntQ + 1'b1;
          end
        end
      end
      VBLANK: begin
        if (periodEnd) begin
          if (cntQ == CntVbLast) begin
            cntD = '0;
            if (enable) begin
              startPulse = 1'b1;
              stateD     = HSYNC;
              lineD      = '0;
              addrD      = '0;
            end else begin
              stateD = IDLE;
            end
          end else begin
            cntD = cntQ + 1'b1;
          end
        end
      end
      default: stateD = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ   <= IDLE;
      divQ     <= '0;
      cntQ     <= '0;
      lineQ    <= '0;
      addrQ    <= '0;
      parityQ  <= 1'b0;
      rdValidQ <= 1'b0;
      holdQ    <= '0;
    end else begin
      stateQ   <= stateD;
      divQ     <= divD;
      cntQ     <= cntD;
      lineQ    <= lineD;
      addrQ    <= addrD;
      parityQ  <= parityD;
      rdValidQ <= rdEn;
      holdQ    <= elData;
    end
  end

`ifdef EL_FRC_GRAY_EN
  assign planeNib = parityQ ? rdData[7:4] : rdData[3:0];
`else
  logic unusedLowPlane;
  assign planeNib       = rdData[7:4];
  assign unusedLowPlane = ^rdData[3:0];
`endif

  assign rdEn        = (stateQ == DATA) && tick;
  assign rdAddr      = rdEn ? addrQ : '0;
  // RAM data lands one clk after the tick and is then held for the rest of the pixel period.
  assign elData      = (stateQ != DATA) ? 4'h0 : (rdValidQ ? planeNib : holdQ);
  assign elVclk      = (stateQ == DATA) && (divQ >= DivHalf);
  assign elHs        = (stateQ == HSYNC);
  assign elVs        = (stateQ == HSYNC) && (lineQ == '0);
  assign frameParity = parityQ;
  assign frameStart  = startPulse && !rst;

endmodule

// File: tb/tb_el_scan_out.sv
// Bench for el_scan_out: timing-based reference model feeds event queues; a negedge monitor checks them.
module tb_el_scan_out;

  localparam int HB = 10;
  localparam int VL = 5;
  localparam int CD = 6;
  localparam int HL = 3;
  localparam int VB = 4;
  localparam int LineClk  = (HL + HB) * CD;
  localparam int FrameClk = (VL * (HL + HB) + VB) * CD;
  localparam int Never    = 32'h7fffffff;
`ifdef EL_FRC_GRAY_EN
  localparam bit GrayEn = 1'b1;
`else
  localparam bit GrayEn = 1'b0;
`endif

  typedef struct {
    int cyc;
    int val;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [14:0] rdAddr;
  logic        rdEn;
  logic [7:0]  rdData;
  logic [3:0]  elData;
  logic        elVclk, elHs, elVs, frameParity, frameStart;

  el_scan_out #(
    .H_BYTES(HB),
    .V_LINES(VL),
    .CLK_DIV(CD),
    .HS_LEN (HL),
    .V_BLANK(VB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .rdAddr     (rdAddr),
    .rdEn       (rdEn),
    .rdData     (rdData),
    .elData     (elData),
    .elVclk     (elVclk),
    .elHs       (elHs),
    .elVs       (elVs),
    .frameParity(frameParity),
    .frameStart (frameStart)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:HB*VL-1];
  int cyc = 0;
  int total = 0;
  int bad = 0;
  ev_t expRd[$], expNib[$], expStart[$], expHs[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rdEn) rdData <= (int'(rdAddr) < HB * VL) ? mem[rdAddr] : 8'h00;
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int nibOf(input logic [7:0] b, input int par);
    return (GrayEn && (par % 2 == 0)) ? int'(b[3:0]) : int'(b[7:4]);
  endfunction

  // Expected events of one frame whose first HSYNC clk is f; events observed after cut are dropped.
  task automatic pushFrame(input int f, input int par, input int cut);
    ev_t e;
    if (f - 1 <= cut) begin
      e.cyc = f - 1; e.val = par; expStart.push_back(e);
    end
    for (int l = 0; l < VL; l++) begin
      int hs;
      hs = f + l * LineClk;
      if (hs + HL * CD <= cut) begin
        e.cyc = hs; e.val = (l == 0) ? 1 : 0; expHs.push_back(e);
      end
      for (int b = 0; b < HB; b++) begin
        int rc;
        int a;
        rc = hs + (HL + b) * CD;
        a  = l * HB + b;
        if (rc <= cut) begin
          e.cyc = rc; e.val = a; expRd.push_back(e);
        end
        if (rc + CD <= cut) begin
          e.cyc = rc + CD - 1; e.val = nibOf(mem[a], par); expNib.push_back(e);
        end
      end
    end
  endtask

  task automatic waitUntil(input int c);
    do begin
      @(posedge clk);
      #1;
    end while (cyc < c);
  endtask

  task automatic doReset(input int n);
    rst = 1'b1;
    enable = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drainCheck();
    chk("rd_left", expRd.size(), 0);
    chk("nib_left", expNib.size(), 0);
    chk("start_left", expStart.size(), 0);
    chk("hs_left", expHs.size(), 0);
  endtask

  // Monitor
  logic prevVclk = 1'b0, prevHs = 1'b0, hsVs = 1'b0, idleWatch = 1'b0, idleBad = 1'b0;
  logic [3:0] prevData = 4'h0;
  int hsStart = 0;

  always @(negedge clk) begin
    ev_t e;
    if (rdEn) begin
      if (expRd.size() == 0) chk("rd_stray", 1, 0);
      else begin
        e = expRd.pop_front();
        chk("rd_cycle", cyc, e.cyc);
        chk("rd_addr", int'(rdAddr), e.val);
      end
    end
    if (prevVclk && !elVclk) begin
      if (expNib.size() == 0) chk("nib_stray", 1, 0);
      else begin
        e = expNib.pop_front();
        chk("nib_cycle", cyc - 1, e.cyc);
        chk("nib_data", int'(prevData), e.val);
      end
    end
    if (frameStart) begin
      if (expStart.size() == 0) chk("start_stray", 1, 0);
      else begin
        e = expStart.pop_front();
        chk("start_cycle", cyc, e.cyc);
        chk("start_parity", int'(frameParity), e.val);
      end
    end
    if (elHs && !prevHs) begin
      hsStart <= cyc;
      hsVs    <= elVs;
    end
    if (!elHs && prevHs) begin
      if (expHs.size() == 0) chk("hs_stray", 1, 0);
      else begin
        e = expHs.pop_front();
        chk("hs_start", hsStart, e.cyc);
        chk("hs_len", cyc - hsStart, HL * CD);
        chk("hs_vs", int'(hsVs), e.val);
      end
    end
    if (elVs && !elHs) chk("vs_stray", 1, 0);
    if (idleWatch && (rdEn || elHs || elVs || elVclk || frameStart || frameParity ||
                      (elData != 4'h0) || (rdAddr != 15'd0))) idleBad <= 1'b1;
    prevVclk <= elVclk;
    prevHs   <= elHs;
    prevData <= elData;
  end

  initial begin
    int f, f1, r;
    rst = 1'b1;
    enable = 1'b0;
    for (int i = 0; i < HB * VL; i++) mem[i] = 8'($urandom);

    // Reset and idle with enable low
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    idleWatch = 1'b1;
    repeat (200) @(posedge clk);
    #1;
    idleWatch = 1'b0;
    chk("idle_outputs", int'(idleBad), 0);

    // Three frames of random data; enable drops mid third frame
    f = cyc + 1;
    pushFrame(f, 0, Never);
    pushFrame(f + FrameClk, 1, Never);
    pushFrame(f + 2 * FrameClk, 0, Never);
    enable = 1'b1;
    waitUntil(f + 2 * FrameClk + 2 * LineClk);
    enable = 1'b0;
    waitUntil(f + 3 * FrameClk + 40);
    drainCheck();
    chk("parity_a", int'(frameParity), 1);

    // FRC with 0xF0 everywhere; enable dropped in frame 0 and restored inside its blanking
    doReset(2);
    for (int i = 0; i < HB * VL; i++) mem[i] = 8'hF0;
    f  = cyc + 1;
    f1 = f + FrameClk;
    pushFrame(f, 0, Never);
    pushFrame(f1, 1, Never);
    enable = 1'b1;
    waitUntil(f + LineClk + 5);
    enable = 1'b0;
    waitUntil(f + VL * LineClk + 2 * CD);
    enable = 1'b1;
    waitUntil(f1 + LineClk);
    enable = 1'b0;
    waitUntil(f1 + FrameClk + 40);
    drainCheck();
    chk("parity_b", int'(frameParity), 0);

    // Reset mid-frame in line 2 data with enable held high
    doReset(2);
    for (int i = 0; i < HB * VL; i++) mem[i] = 8'($urandom);
    f = cyc + 1;
    r = f + 2 * LineClk + (HL + 3) * CD + 1;
    pushFrame(f, 0, r);
    enable = 1'b1;
    waitUntil(r);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    pushFrame(r + 2, 0, Never);
    @(negedge clk);
    chk("rst_outputs", int'({rdEn, elHs, elVs, elVclk, frameParity, elData, rdAddr}), 0);
    waitUntil(r + 2 + LineClk);
    enable = 1'b0;
    waitUntil(r + 2 + FrameClk + 40);
    drainCheck();
    chk("parity_c", int'(frameParity), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
